// File: rtl/icache_responder_pkg.sv
// Shared types for the instruction cache: CPU word type, address split,
// frame layout and controller states for the default 16-set geometry.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage

package cache_types_pkg;
    import cpu_types_pkg::*;

    localparam int unsigned ICACHE_SETS  = 16;
    localparam int unsigned ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int unsigned ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;
endpackage

// File: rtl/icache_responder_frame_array.sv
// Frame storage for the instruction cache: one combinational read port,
// one write port and a clear-all that drops every valid bit.
// Only the valid bits are reset; tag and data storage is left uninitialised.
module icache_frame_array
    import cpu_types_pkg::*;
#(
    parameter int unsigned SETS  = 16,
    parameter int unsigned IDX_W = $clog2(SETS),
    parameter int unsigned TAG_W = 32 - IDX_W - 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic [IDX_W-1:0] ridx_i,
    output logic             rvalid_o,
    output logic [TAG_W-1:0] rtag_o,
    output word_t            rdata_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [TAG_W-1:0] wtag_i,
    input  word_t            wdata_i
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    word_t            data_q [SETS];

    // Valid bits: clear-all beats a simultaneous write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (clear_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[widx_i] <= 1'b1;
        end
    end

    // Tag/data payload: written on fill, never reset
    always_ff @(posedge clk_i) begin
        if (we_i && !clear_i) begin
            tag_q[widx_i]  <= wtag_i;
            data_q[widx_i] <= wdata_i;
        end
    end

    // Combinational read of the indexed frame
    always_comb begin
        rvalid_o = valid_q[ridx_i];
        rtag_o   = tag_q[ridx_i];
        rdata_o  = data_q[ridx_i];
    end

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped, read-only, one-word-per-block instruction cache between
// the fetch stage and the memory arbiter. Hits answer combinationally in
// IDLE; misses latch the address and fill from memory in FILL.
// Optional feature: define ICACHE_STATS_EN to add hit_count/miss_count.
module icache_responder
    import cpu_types_pkg::*;
    import cache_types_pkg::*;
#(
    parameter int unsigned SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  word_t       imemaddr,
    output logic        ihit,
    output word_t       imemload,
    input  logic        flush,
    output logic        iREN,
    output word_t       iaddr,
    input  logic        iwait,
    input  word_t       iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    icache_state_t    state_q, state_d;
    logic [29:0]      miss_addr_q, miss_addr_d;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             frame_valid;
    logic [TAG_W-1:0] frame_tag;
    word_t            frame_data;
    logic             hit;
    logic             fill_we;
    logic             unused_bytoff;

    assign req_idx       = imemaddr[IDX_W+1:2];
    assign req_tag       = imemaddr[31:IDX_W+2];
    assign unused_bytoff = ^imemaddr[1:0];

    icache_frame_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_frames (
        .clk_i    (CLK),
        .rst_ni   (nRST),
        .clear_i  (flush),
        .ridx_i   (req_idx),
        .rvalid_o (frame_valid),
        .rtag_o   (frame_tag),
        .rdata_o  (frame_data),
        .we_i     (fill_we),
        .widx_i   (miss_addr_q[IDX_W-1:0]),
        .wtag_i   (miss_addr_q[29:IDX_W]),
        .wdata_i  (iload)
    );

    // Hit detection and fetch-side outputs
    always_comb begin
        hit      = imemREN && frame_valid && (frame_tag == req_tag) && (state_q == IDLE);
        ihit     = hit;
        imemload = frame_data;
    end

    // Next-state, miss latch and memory-side outputs
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        fill_we     = 1'b0;
        iREN        = 1'b0;
        iaddr       = {miss_addr_q, 2'b00};
        unique case (state_q)
            IDLE: begin
                if (imemREN && !hit && !flush) begin
                    miss_addr_d = imemaddr[31:2];
                    state_d     = FILL;
                end
            end
            FILL: begin
                iREN = 1'b1;
                // flush aborts the fill even when the data arrives this cycle
                if (flush) begin
                    state_d = IDLE;
                end else if (!iwait) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state and latched miss address
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, miss_count_q;

    // Hit and miss counters; wrap naturally, untouched by flush
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (hit) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if (state_q == IDLE && state_d == FILL) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
